// File: rtl/fifo_level_pkg.sv
// Shared types for the fifo_level block: decoded per-cycle pointer operation.
package fifo_level_pkg;

  typedef enum logic [1:0] {
    OpIdle = 2'b00,
    OpPush = 2'b01,
    OpPop  = 2'b10,
    OpBoth = 2'b11
  } op_e;

  function automatic op_e decode_op(input logic push, input logic pop);
    return op_e'({pop, push});
  endfunction

endpackage

// File: rtl/fifo_level_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_level_ram #(
  parameter int unsigned B = 8,
  parameter int unsigned W = 4
) (
  input  logic         i_clk,
  input  logic         i_we,
  input  logic [W-1:0] i_waddr,
  input  logic [B-1:0] i_wdata,
  input  logic [W-1:0] i_raddr,
  output logic [B-1:0] o_rdata
);

  logic [B-1:0] r_mem [2**W];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_level.sv
// First-word-fall-through FIFO with registered occupancy, threshold flags and sticky errors.
module fifo_level
  import fifo_level_pkg::*;
#(
  parameter int unsigned B        = 8,
  parameter int unsigned W        = 4,
  parameter int unsigned AF_LEVEL = 2**W - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         rd,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         err_clr,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam logic [W:0]   Depth   = {1'b1, {W{1'b0}}};
  localparam logic [W:0]   AfLevel = AF_LEVEL[W:0];
  localparam logic [W:0]   AeLevel = AE_LEVEL[W:0];
  localparam logic [W-1:0] PtrOne  = W'(1);
  localparam logic [W:0]   CntOne  = (W + 1)'(1);

  if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= 2**W))) begin : g_param_check
    $error("fifo_level: parameters must satisfy AE_LEVEL < AF_LEVEL <= 2**W");
  end

  logic [W-1:0] r_wr_ptr, r_rd_ptr, w_wr_ptr_d, w_rd_ptr_d;
  logic [W:0]   r_count, w_count_d;
  logic         r_empty, r_full, r_almost_empty, r_almost_full;
  logic         r_overflow, r_underflow, w_overflow_d, w_underflow_d;
  logic         w_do_wr, w_do_rd, w_ovf_evt, w_udf_evt, w_ram_we;
  op_e          w_op;

  // A full FIFO still takes a write when a read frees the head slot in the same cycle.
  assign w_do_wr   = wr & (~r_full | rd);
  assign w_do_rd   = rd & ~r_empty;
  assign w_ovf_evt = wr & r_full & ~rd & ~flush;
  assign w_udf_evt = rd & r_empty & ~flush;
  assign w_op      = decode_op(w_do_wr, w_do_rd);
  assign w_ram_we  = w_do_wr & ~flush & ~reset;

  always_comb begin
    w_wr_ptr_d = r_wr_ptr;
    w_rd_ptr_d = r_rd_ptr;
    w_count_d  = r_count;
    if (flush) begin
      w_wr_ptr_d = '0;
      w_rd_ptr_d = '0;
      w_count_d  = '0;
    end else begin
      if (w_do_wr) w_wr_ptr_d = r_wr_ptr + PtrOne;
      if (w_do_rd) w_rd_ptr_d = r_rd_ptr + PtrOne;
      unique case (w_op)
        OpPush:  w_count_d = r_count + CntOne;
        OpPop:   w_count_d = r_count - CntOne;
        default: w_count_d = r_count;
      endcase
    end
  end

  // A fresh error in the clearing cycle wins over err_clr.
  assign w_overflow_d  = (r_overflow & ~err_clr) | w_ovf_evt;
  assign w_underflow_d = (r_underflow & ~err_clr) | w_udf_evt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_empty <= 1'b1;
      r_almost_full  <= 1'b0;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      r_wr_ptr       <= w_wr_ptr_d;
      r_rd_ptr       <= w_rd_ptr_d;
      r_count        <= w_count_d;
      r_empty        <= (w_count_d == '0);
      r_full         <= (w_count_d == Depth);
      r_almost_empty <= (w_count_d <= AeLevel);
      r_almost_full  <= (w_count_d >= AfLevel);
      r_overflow     <= w_overflow_d;
      r_underflow    <= w_underflow_d;
    end
  end

  fifo_level_ram #(
    .B(B),
    .W(W)
  ) u_ram (
    .i_clk  (clk),
    .i_we   (w_ram_we),
    .i_waddr(r_wr_ptr),
    .i_wdata(w_data),
    .i_raddr(r_rd_ptr),
    .o_rdata(r_data)
  );

  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_empty = r_almost_empty;
  assign almost_full  = r_almost_full;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_level.sv
// Scoreboard bench for fifo_level (B=8, W=4): fill, overflow, underflow, wrap, flush, reset.
module tb_fifo_level;

  logic       clk = 1'b0;
  logic       reset, flush, rd, wr, err_clr;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] count;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         mc       = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_d;

  fifo_level #(
    .B(8),
    .W(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .rd          (rd),
    .wr          (wr),
    .w_data      (w_data),
    .err_clr     (err_clr),
    .r_data      (r_data),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; rd = 1'b0; wr = 1'b0; err_clr = 1'b0; w_data = 8'h00;
    step();
    step();
    reset = 1'b0;
    mc = 0;
    sb.delete();
    n_checks++;
    if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++;
    if ({empty, full, almost_empty, almost_full, overflow, underflow} !== 6'b101000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 101000",
               {empty, full, almost_empty, almost_full, overflow, underflow});
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      wr = 1'b1; w_data = 8'(i);
      sb.push_back(8'(i));
      step();
      mc++;
      n_checks++;
      if (count !== 5'(mc)) begin n_fail++; $display("FAIL fill_count got %0d want %0d", count, mc); end
      n_checks++;
      if (almost_full !== (mc >= 14)) begin
        n_fail++; $display("FAIL fill_almost_full at %0d got %b want %b", mc, almost_full, mc >= 14);
      end
      n_checks++;
      if ({empty, full, almost_empty} !== {1'b0, mc == 16, mc <= 2}) begin
        n_fail++;
        $display("FAIL fill_flags at %0d got %b want %b", mc, {empty, full, almost_empty},
                 {1'b0, mc == 16, mc <= 2});
      end
    end
    wr = 1'b0;
  endtask

  task automatic test_overflow_drain();
    wr = 1'b1; w_data = 8'hAA;
    step();
    wr = 1'b0;
    n_checks++;
    if ({overflow, full, count} !== {1'b1, 1'b1, 5'd16}) begin
      n_fail++; $display("FAIL overflow got ovf=%b full=%b cnt=%0d want 1 1 16", overflow, full, count);
    end
    // Simultaneous read and write while full: both accepted.
    rd = 1'b1; wr = 1'b1; w_data = 8'hBB;
    exp_d = sb.pop_front();
    sb.push_back(8'hBB);
    n_checks++;
    if (r_data !== exp_d) begin n_fail++; $display("FAIL full_rdwr_head got %h want %h", r_data, exp_d); end
    step();
    wr = 1'b0;
    n_checks++;
    if ({full, count} !== {1'b1, 5'd16}) begin
      n_fail++; $display("FAIL full_rdwr got full=%b cnt=%0d want 1 16", full, count);
    end
    for (int i = 0; i < 16; i++) begin
      rd = 1'b1;
      exp_d = sb.pop_front();
      n_checks++;
      if (r_data !== exp_d) begin n_fail++; $display("FAIL drain_data got %h want %h", r_data, exp_d); end
      step();
      mc--;
      n_checks++;
      if ({count, almost_empty} !== {5'(mc), mc <= 2}) begin
        n_fail++; $display("FAIL drain_count got %0d/%b want %0d/%b", count, almost_empty, mc, mc <= 2);
      end
    end
    rd = 1'b0;
    n_checks++;
    if ({empty, full} !== 2'b10) begin n_fail++; $display("FAIL drain_empty got %b want 10", {empty, full}); end
  endtask

  task automatic test_underflow();
    rd = 1'b1;
    step();
    rd = 1'b0;
    n_checks++;
    if ({underflow, count} !== {1'b1, 5'd0}) begin
      n_fail++; $display("FAIL underflow got udf=%b cnt=%0d want 1 0", underflow, count);
    end
    rd = 1'b1; wr = 1'b1; w_data = 8'h55;
    sb.push_back(8'h55);
    step();
    rd = 1'b0; wr = 1'b0;
    mc = 1;
    n_checks++;
    if ({count, r_data, empty} !== {5'd1, 8'h55, 1'b0}) begin
      n_fail++; $display("FAIL empty_rdwr got cnt=%0d data=%h empty=%b want 1 55 0", count, r_data, empty);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_checks++;
    if ({overflow, underflow} !== 2'b00) begin
      n_fail++; $display("FAIL err_clr got %b want 00", {overflow, underflow});
    end
    rd = 1'b1;
    exp_d = sb.pop_front();
    step();
    mc = 0;
    // New underflow in the same cycle as err_clr must keep the flag set.
    err_clr = 1'b1;
    step();
    rd = 1'b0;
    n_checks++;
    if ({underflow, empty} !== 2'b11) begin
      n_fail++; $display("FAIL err_clr_race got %b want 11", {underflow, empty});
    end
    step();
    err_clr = 1'b0;
    n_checks++;
    if (underflow !== 1'b0) begin n_fail++; $display("FAIL err_clr_late got %b want 0", underflow); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    d = 8'h20;
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1; w_data = d; sb.push_back(d); d++;
      step();
    end
    mc = 8;
    for (int i = 0; i < 40; i++) begin
      rd = 1'b1; wr = 1'b1; w_data = d; sb.push_back(d); d++;
      exp_d = sb.pop_front();
      n_checks++;
      if (r_data !== exp_d) begin n_fail++; $display("FAIL b2b_data got %h want %h", r_data, exp_d); end
      step();
      n_checks++;
      if (count !== 5'd8) begin n_fail++; $display("FAIL b2b_count got %0d want 8", count); end
    end
    wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_d = sb.pop_front();
      n_checks++;
      if (r_data !== exp_d) begin n_fail++; $display("FAIL b2b_tail got %h want %h", r_data, exp_d); end
      step();
    end
    rd = 1'b0;
    mc = 0;
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty got %b want 1", empty); end
  endtask

  task automatic test_flush();
    rd = 1'b1;
    step();
    rd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; w_data = 8'(8'h60 + i);
      step();
    end
    wr = 1'b0;
    n_checks++;
    if (count !== 5'd5) begin n_fail++; $display("FAIL flush_pre got %0d want 5", count); end
    flush = 1'b1; rd = 1'b1; wr = 1'b1; w_data = 8'h99;
    step();
    flush = 1'b0; rd = 1'b0; wr = 1'b0;
    sb.delete();
    n_checks++;
    if ({count, empty, full, almost_empty, almost_full} !== {5'd0, 4'b1010}) begin
      n_fail++;
      $display("FAIL flush_state got cnt=%0d flags=%b want 0 1010", count,
               {empty, full, almost_empty, almost_full});
    end
    n_checks++;
    if ({overflow, underflow} !== 2'b01) begin
      n_fail++; $display("FAIL flush_sticky got %b want 01", {overflow, underflow});
    end
    wr = 1'b1; w_data = 8'h33;
    step();
    wr = 1'b0;
    mc = 1;
    n_checks++;
    if ({r_data, count} !== {8'h33, 5'd1}) begin
      n_fail++; $display("FAIL flush_write got %h/%0d want 33/1", r_data, count);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) begin
      wr = 1'b1; w_data = 8'(8'h70 + i);
      step();
    end
    n_checks++;
    if (count !== 5'd10) begin n_fail++; $display("FAIL rst_pre got %0d want 10", count); end
    reset = 1'b1; wr = 1'b1; w_data = 8'h77;
    step();
    reset = 1'b0; wr = 1'b0;
    n_checks++;
    if ({count, empty, full, almost_empty, almost_full, overflow, underflow} !==
        {5'd0, 6'b101000}) begin
      n_fail++;
      $display("FAIL rst_mid got cnt=%0d flags=%b want 0 101000", count,
               {empty, full, almost_empty, almost_full, overflow, underflow});
    end
    wr = 1'b1; w_data = 8'h44;
    step();
    wr = 1'b0;
    n_checks++;
    if ({r_data, count} !== {8'h44, 5'd1}) begin
      n_fail++; $display("FAIL rst_first_write got %h/%0d want 44/1", r_data, count);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow_drain();
    test_underflow();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_level.md
FIFO_LEVEL -- requirements
Module: fifo_level

Interface
REQ-001 The block SHALL have parameter B, default 8, data word width in bits.
REQ-002 The block SHALL have parameter W, default 4, address bits; depth is 2**W words.
REQ-003 The block SHALL have parameter AF_LEVEL, default 2**W-2, occupancy at or above which almost_full asserts.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, occupancy at or below which almost_empty asserts.
REQ-005 The block SHALL have these ports, one per line:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of FIFO contents
- rd  in  1  read request; pops the head word
- wr  in  1  write request; pushes w_data
- w_data  in  B  write data
- err_clr  in  1  clears the sticky error flags
- r_data  out  B  head word, combinational from storage at the read pointer
- empty  out  1  registered; occupancy is 0
- full  out  1  registered; occupancy is 2**W
- almost_empty  out  1  registered; count <= AE_LEVEL
- almost_full  out  1  registered; count >= AF_LEVEL
- count  out  W+1  registered occupancy, 0 to 2**W
- overflow  out  1  sticky; a write was dropped
- underflow  out  1  sticky; a read was ignored
REQ-006 The block SHALL use one clock, clk, with a synchronous, active-high reset, reset.

Function
REQ-007 The block SHALL present the head word on r_data with zero latency (first-word-fall-through); r_data is undefined while empty.
REQ-008 An accepted write SHALL store w_data at the write pointer on the clock edge and advance the pointer modulo 2**W.
REQ-009 An accepted read SHALL advance the read pointer modulo 2**W on the clock edge.
REQ-010 rd=1, wr=0, not empty SHALL pop one word and decrement count.
REQ-011 rd=0, wr=1, not full SHALL push one word and increment count.
REQ-012 rd=1, wr=1, neither empty nor full SHALL push and pop in the same cycle, leaving count unchanged.
REQ-013 rd=1, wr=1 while full SHALL accept both operations; count stays 2**W and full stays 1.
REQ-014 rd=1, wr=1 while empty SHALL accept the write and ignore the read; count becomes 1 and underflow sets.
REQ-015 wr=1 while full without rd SHALL leave storage, pointers and count unchanged and set overflow.
REQ-016 rd=1 while empty SHALL leave pointers and count unchanged and set underflow.
REQ-017 Flags SHALL be computed from the next count so they are valid in the cycle count updates: empty=(count==0), full=(count==2**W), and the almost flags per REQ-003 and REQ-004.
REQ-018 flush=1 SHALL take priority over rd and wr: the pointers zero and count becomes 0, with empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0); the sticky flags are unchanged.
REQ-019 err_clr=1 SHALL clear overflow and underflow next cycle; a new error in the same cycle SHALL win, leaving the flag set.
REQ-020 Parameters SHALL satisfy 0<=AE_LEVEL<AF_LEVEL<=2**W; an elaboration check SHALL flag a violation.

Reset
REQ-021 reset=1 SHALL, on the clock edge, set pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0; it overrides flush, rd, wr and err_clr.
REQ-022 Storage contents SHALL NOT be reset.
REQ-023 Reset asserted mid-operation SHALL discard all stored words; the first write after reset is the next head word.

Structure
REQ-024 Depth-derived constants (DEPTH=2**W, count width W+1) SHALL be derived locally; no shared package is needed.
REQ-025 Storage SHALL be a sub-module fifo_level_ram (one write port, one asynchronous read port, parameters B and W), instantiated once; all control logic stays in fifo_level.

Verification
REQ-026 B=8, W=4: after reset, write 0x01..0x10 over 16 cycles -> full=1, count=16, almost_full from count=14, empty=0.
REQ-027 From full, a 17th write of 0xAA -> overflow=1, count=16; then read 16 words -> r_data sequence 0x01..0x10, then empty=1.
REQ-028 From empty, rd=1 alone -> underflow=1, count=0; then rd=1, wr=1 with 0x55 -> count=1, r_data=0x55; then err_clr=1 -> underflow=0.
REQ-029 Hold count=8 and drive rd=1, wr=1 for 40 cycles with incrementing data -> count stays 8, data order is preserved across pointer wrap-around.
REQ-030 At count=5, assert flush with rd=1, wr=1 -> next cycle count=0, empty=1, sticky flags unchanged; a subsequent write of 0x33 -> r_data=0x33.
REQ-031 At count=10, assert reset with wr=1 -> next cycle count=0, empty=1, all flags cleared, no write taken.
